// File: rtl/cla_add_pipe_if.sv
// Operand/result handshake bundle for cla_add_pipe.
// The sub signal exists only when CLA_ADD_SUB_EN is defined.
interface cla_add_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CLA_ADD_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid,
`ifdef CLA_ADD_SUB_EN
        output sub,
`endif
        output a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid,
`ifdef CLA_ADD_SUB_EN
        input  sub,
`endif
        input  a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready flow control.
// Optional subtract support is enabled with the CLA_ADD_SUB_EN macro.
module cla_add_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input logic          clk,
    input logic          rst_n,
    cla_add_pipe_if.slave bus
);
    localparam int unsigned NIB = WIDTH / 4;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_g;
    logic             s1_c0;
    logic             s1_a_msb;
    logic             s1_b_msb;

    logic [WIDTH-1:0] bb_c;
    logic             c0_c;
    logic             in_load_c;
    logic             s2_load_c;
    logic [WIDTH-1:0] carry_c;
    logic [NIB:0]     nib_c;
    logic [WIDTH-1:0] sum_c;
    logic             ovf_c;

    // Effective second operand and carry-in
`ifdef CLA_ADD_SUB_EN
    assign bb_c = bus.sub ? ~bus.b : bus.b;
    assign c0_c = bus.sub | bus.cin;
`else
    assign bb_c = bus.b;
    assign c0_c = bus.cin;
`endif

    assign bus.in_ready = !s1_valid || !bus.out_valid || bus.out_ready;
    assign in_load_c    = bus.in_valid && bus.in_ready;
    assign s2_load_c    = s1_valid && (!bus.out_valid || bus.out_ready);

    // Stage 1: register propagate/generate terms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_p     <= '0;
            s1_g     <= '0;
            s1_c0    <= 1'b0;
            s1_a_msb <= 1'b0;
            s1_b_msb <= 1'b0;
        end else if (in_load_c) begin
            s1_valid <= 1'b1;
            s1_p     <= bus.a ^ bb_c;
            s1_g     <= bus.a & bb_c;
            s1_c0    <= c0_c;
            s1_a_msb <= bus.a[WIDTH-1];
            s1_b_msb <= bb_c[WIDTH-1];
        end else if (s2_load_c) begin
            s1_valid <= 1'b0;
        end
    end

    assign nib_c[0] = s1_c0;

    // Per-nibble full lookahead; group G/P chain the nibble carry-ins
    for (genvar n = 0; n < NIB; n++) begin : g_nib
        logic [3:0] p;
        logic [3:0] g;
        logic       ci;
        logic       grp_g;
        logic       grp_p;

        assign p  = s1_p[4*n +: 4];
        assign g  = s1_g[4*n +: 4];
        assign ci = nib_c[n];

        assign carry_c[4*n]     = ci;
        assign carry_c[4*n + 1] = g[0] | (p[0] & ci);
        assign carry_c[4*n + 2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        assign carry_c[4*n + 3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                                | (p[2] & p[1] & p[0] & ci);

        assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]);
        assign grp_p = &p;

        assign nib_c[n+1] = grp_g | (grp_p & ci);
    end

    assign sum_c = s1_p ^ carry_c;
    assign ovf_c = (s1_a_msb == s1_b_msb) && (sum_c[WIDTH-1] != s1_a_msb);

    // Stage 2: result and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.sum       <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.zero      <= 1'b0;
        end else if (s2_load_c) begin
            bus.out_valid <= 1'b1;
            bus.sum       <= sum_c;
            bus.cout      <= nib_c[NIB];
            bus.ovf       <= ovf_c;
            bus.zero      <= ~|sum_c;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cla_add_pipe.sv
// Randomized self-checking bench for cla_add_pipe at WIDTH=32 and WIDTH=8.
// Sub tests run when CLA_ADD_SUB_EN is defined.
module tb_cla_add_pipe;
    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_v;
    logic [31:0] b_v;
    logic        cin_v;
    logic        sub_v;
    int          n_checks;
    int          n_errors;
    res_t        q32[$];
    res_t        q8[$];

    cla_add_pipe_if #(.WIDTH(32)) if32 ();
    cla_add_pipe_if #(.WIDTH(8))  if8 ();

    cla_add_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
    cla_add_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

    assign if32.in_valid  = in_valid;
    assign if32.out_ready = out_ready;
    assign if32.a         = a_v;
    assign if32.b         = b_v;
    assign if32.cin       = cin_v;
    assign if8.in_valid   = in_valid;
    assign if8.out_ready  = out_ready;
    assign if8.a          = a_v[7:0];
    assign if8.b          = b_v[7:0];
    assign if8.cin        = cin_v;
`ifdef CLA_ADD_SUB_EN
    assign if32.sub       = sub_v;
    assign if8.sub        = sub_v;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: integer arithmetic on w-bit values, signed range test for overflow
    function automatic res_t model(input int unsigned w, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin, input logic sub);
        longint m, ua, ub, c, full, sa, sb, ss;
        res_t   r;
        m    = (longint'(1) << w) - 1;
        ua   = longint'({32'd0, a}) & m;
        ub   = (sub ? ~longint'({32'd0, b}) : longint'({32'd0, b})) & m;
        c    = (sub || cin) ? 1 : 0;
        full = ua + ub + c;
        sa   = (ua > (m >> 1)) ? ua - (m + 1) : ua;
        sb   = (ub > (m >> 1)) ? ub - (m + 1) : ub;
        ss   = sa + sb + c;
        r.sum  = 32'(full & m);
        r.cout = ((full >> w) & 1) != 0;
        r.ovf  = (ss > (m >> 1)) || (ss < -((m + 1) / 2));
        r.zero = (full & m) == 0;
        return r;
    endfunction

    // Evaluate transfers mid-cycle, then step past the next rising edge
    task automatic cycle();
        res_t e;
        @(negedge clk);
        if (in_valid && if32.in_ready) q32.push_back(model(32, a_v, b_v, cin_v, sub_v));
        if (in_valid && if8.in_ready)  q8.push_back(model(8, a_v, b_v, cin_v, sub_v));
        if (if32.out_valid && out_ready) begin
            if (q32.size() == 0) check("sb32_extra", 1, 0);
            else begin
                e = q32.pop_front();
                check("sum32", 64'(if32.sum), 64'(e.sum));
                check("flags32", 64'({if32.cout, if32.ovf, if32.zero}), 64'({e.cout, e.ovf, e.zero}));
            end
        end
        if (if8.out_valid && out_ready) begin
            if (q8.size() == 0) check("sb8_extra", 1, 0);
            else begin
                e = q8.pop_front();
                check("sum8", 64'(if8.sum), 64'(e.sum));
                check("flags8", 64'({if8.cout, if8.ovf, if8.zero}), 64'({e.cout, e.ovf, e.zero}));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_expect(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic cin, input logic sub, input logic [31:0] exp_sum,
                               input logic [2:0] exp_flags);
        int n;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        a_v = a; b_v = b; cin_v = cin; sub_v = sub;
        cycle();
        in_valid = 1'b0;
        n = 0;
        while (!if32.out_valid && n < 4) begin
            cycle();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd1);
        check({tag, "_sum"}, 64'(if32.sum), 64'(exp_sum));
        check({tag, "_flags"}, 64'({if32.cout, if32.ovf, if32.zero}), 64'(exp_flags));
        cycle();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 64'(if32.out_valid), 64'd0);
        check({tag, "_sum"}, 64'(if32.sum), 64'd0);
        check({tag, "_flags"}, 64'({if32.cout, if32.ovf, if32.zero}), 64'd0);
        check({tag, "_in_ready"}, 64'(if32.in_ready), 64'd1);
        check({tag, "_out_valid8"}, 64'(if8.out_valid), 64'd0);
    endtask

    initial begin
        int n;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_v = '0; b_v = '0; cin_v = 1'b0; sub_v = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Boundary cases: carry-out to zero, signed overflow
        send_expect("carry_zero", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 3'b101);
        send_expect("overflow", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 3'b010);
        send_expect("cin", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 3'b000);
`ifdef CLA_ADD_SUB_EN
        send_expect("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 3'b000);
        send_expect("sub_ovf", 32'h8000_0000, 32'd1, 1'b0, 1'b1, 32'h7FFF_FFFF, 3'b110);
`endif

        // Backpressure: two fill the pipe, third waits
        out_ready = 1'b0; in_valid = 1'b1; cin_v = 1'b0; sub_v = 1'b0;
        a_v = 32'd1; b_v = 32'd2; cycle();
        a_v = 32'd3; b_v = 32'd4; cycle();
        a_v = 32'd5; b_v = 32'd6;
        check("bp_in_ready", 64'(if32.in_ready), 64'd0);
        check("bp_hold_sum", 64'(if32.sum), 64'd3);
        cycle();
        check("bp_stall_sum", 64'(if32.sum), 64'd3);
        check("bp_stall_valid", 64'(if32.out_valid), 64'd1);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("bp_sum2", 64'(if32.sum), 64'd7);
        cycle();
        check("bp_sum3", 64'(if32.sum), 64'd11);
        cycle();
        check("bp_drained", 64'(q32.size()), 64'd0);

        // Reset while the pipe is full
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_v = $urandom; b_v = $urandom; cycle();
        end
        #2 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        q32.delete(); q8.delete();
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("no_stale", 64'(if32.out_valid), 64'd0);
        end

        // Random streaming with ~30% output stalls
        for (int i = 0; i < 1000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) >= 3);
            a_v = $urandom; b_v = $urandom; cin_v = 1'($urandom);
`ifdef CLA_ADD_SUB_EN
            sub_v = 1'($urandom);
`endif
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 10) begin
            cycle();
            n++;
        end
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain8", 64'(q8.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cla_add_pipe.md
# cla_add_pipe

Two-stage pipelined carry-lookahead adder that feeds operand generate/propagate terms into 4-bit lookahead groups and consumes the resulting carries to form sums. It sits in the ALU datapath between operand selection and writeback. It uses a valid/ready handshake so the ALU can stall it. It also produces carry, overflow and zero flags for branch and SLT logic.

## Interface
- WIDTH, 32, operand width; multiple of 4, range 4..64
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  stage 1 can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in
- sub  in  1  subtract request; present only with CLA_ADD_SUB_EN
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of bit WIDTH-1
- ovf  out  1  signed overflow
- zero  out  1  sum == 0

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Stage 1 (accept): effective B is bb = sub ? ~b : b, and effective carry-in is c0 = sub ? 1 : cin.
  - Registers per-bit p = a ^ bb and g = a & bb, plus c0, a[WIDTH-1] and bb[WIDTH-1]. Sets s1_valid.
- Stage 2: splits p/g into WIDTH/4 nibbles.
  - Per nibble, internal carries follow full lookahead: c[i] = g[i] | p[i]&g[i-1] | … | p[i]&…&p[0]&cin_n.
  - Nibble group G/P feed nibble carry-ins across the word; nibble 0 carry-in is c0.
  - Per bit, sum[i] = p[i] ^ carry-into-bit-i.
  - cout = carry out of the top nibble.
  - ovf = (a_msb == bb_msb) && (sum_msb != a_msb).
  - zero = ~|sum.
  - Registers sum, cout, ovf and zero, and sets out_valid.
- All arithmetic is modulo 2^WIDTH. cout=1 on subtract means no borrow.
- Flow control:
  - s2 loads when s1_valid && (!out_valid || out_ready).
  - s1 loads when in_valid && in_ready.
  - in_ready = !s1_valid || !out_valid || out_ready.
- Held stage registers do not change while stalled. Transactions leave in acceptance order; none are dropped or duplicated.
- Simultaneous in-transfer and s1→s2 move in the same cycle: s1 takes the new operands and s2 takes the old ones.

## Timing
- Reset (rst_n low, asynchronous): s1_valid=0, out_valid=0, sum=0, cout=0, ovf=0, zero=0, and all stage-1 registers are 0. in_ready=1.
- Latency: an operand accepted at edge N gives out_valid=1 after edge N+1, provided the consumer is not stalling.
- Throughput: one result per cycle while out_ready=1.
- Stall: with out_valid=1 and out_ready=0, a second transaction can still fill stage 1. in_ready then reads 0 until out_ready rises.
- in_ready depends combinationally on out_ready. No other input-to-output combinational paths exist.
- Reset asserted mid-operation discards all in-flight transactions. The first cycle after release behaves as post-reset.

## Configuration
- CLA_ADD_SUB_EN defined: the sub port exists and subtraction works as described.
- CLA_ADD_SUB_EN undefined: there is no sub port; bb = b and c0 = cin. The module is a pure adder, and stage 1 carries no inverter mux.

## Test plan
- Reset: assert rst_n=0 mid-stream -> out_valid=0, sum=0, flags=0, in_ready=1. After release, no stale result appears.
- Carry/zero: a=0xFFFFFFFF, b=0x00000001, cin=0 -> 2 cycles later sum=0x00000000, cout=1, zero=1, ovf=0.
- Overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, ovf=1, cout=0, zero=0.
- Backpressure: send T1=(1,2), T2=(3,4), T3=(5,6) back-to-back with out_ready=0.
  - After T1 and T2 are accepted, in_ready=0 and sum holds 3.
  - Raise out_ready -> sums 3, 7, 11 on consecutive cycles with no loss.
- Streaming: 1000 random pairs with random cin and out_ready toggling ~30% of cycles -> every result matches the reference model a+b+cin (WIDTH=32 and WIDTH=8), in order.
- Subtract (CLA_ADD_SUB_EN): a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, ovf=0.
  - a=0x80000000, b=1, sub=1 -> sum=0x7FFFFFFF, ovf=1, cout=1.
